// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory adapter: funct3 codes,
// FSM state encoding and request-legality helpers.
// Used by lsu_align and lsu_mem_adapter.
package lsu_pkg;

  // RV32 load/store width codes (stores use the first three only)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD    = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_MERGE = 3'd3;
  localparam logic [2:0] ST_WR    = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    RD    = ST_RD,
    WAIT  = ST_WAIT,
    MERGE = ST_MERGE,
    WR    = ST_WR,
    RESP  = ST_RESP
  } state_e;

  // Stores only have B/H/W; loads add the unsigned B/H variants.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

  // Halfwords need addr[0]==0, words need addr[1:0]==0.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (f3 == F3_H || f3 == F3_HU) bad = off[0];
    if (f3 == F3_W)                bad = (off != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: load extract + sign/zero extend, store byte/half merge.
// Latency: purely combinational.
// Backpressure: none, no state.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Select the addressed lane; halfwords only look at off[1]
  always_comb begin
    byte_v = old_word_i[{off_i, 3'b000} +: 8];
    half_v = old_word_i[{off_i[1], 4'b0000} +: 16];
  end

  // Extend the selected lane according to the load width code
  always_comb begin
    load_data_o = old_word_i;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_data_o = {24'h0, byte_v};
      F3_H:    load_data_o = {{16{half_v[15]}}, half_v};
      F3_HU:   load_data_o = {16'h0, half_v};
      default: load_data_o = old_word_i;
    endcase
  end

  // Overwrite only the addressed bytes of the word read back from memory
  always_comb begin
    store_word_o = old_word_i;
    case (funct3_i)
      F3_B:    store_word_o[{off_i, 3'b000} +: 8]      = wdata_i[7:0];
      F3_H:    store_word_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: store_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_adapter.sv
// RV32 load/store adapter in front of a word-addressed, 1-cycle-read memory.
// Latency: load 3, SW 2, SB/SH 4 (read-modify-write), error 1 cycle after accept.
// Backpressure: req_ready only in IDLE; one request in flight. Macro LSU_MISALIGN_CHECK_EN enables error responses.
module lsu_mem_adapter
  import lsu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [2:0]   req_funct3,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_data,
  output logic         resp_err,
  output logic         mem_rdEna,
  output logic [N-1:0] mem_rdAddr,
  output logic         mem_wrEna,
  output logic [N-1:0] mem_wrAddr,
  output logic [N-1:0] mem_wrData,
  input  logic [N-1:0] mem_rdData
);

  state_e       state_q, state_d;
  logic [N-1:0] addr_q, wdata_q, resp_data_q, wr_data_q;
  logic         we_q, err_q;
  logic [2:0]   f3_q;

  logic         accept;
  logic         req_err;
  logic [2:0]   req_f3;
  logic [N-1:0] load_data, store_word;

  assign accept = req_valid && (state_q == IDLE);

  // Classify the incoming request; without the check, bad codes become word accesses
  always_comb begin
`ifdef LSU_MISALIGN_CHECK_EN
    req_err = !f3_legal(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
    req_f3  = req_funct3;
`else
    req_err = 1'b0;
    req_f3  = f3_legal(req_we, req_funct3) ? req_funct3 : F3_W;
`endif
  end

  lsu_align u_align (
    .old_word_i   (mem_rdData),
    .wdata_i      (wdata_q),
    .funct3_i     (f3_q),
    .off_i        (addr_q[1:0]),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    mem_rdEna  = 1'b0;
    mem_wrEna  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (req_err)                          state_d = RESP;
          else if (req_we && (req_f3 == F3_W))  state_d = WR;
          else                                  state_d = RD;
        end
      end
      RD: begin
        mem_rdEna = 1'b1;
        state_d   = we_q ? MERGE : WAIT;
      end
      WAIT:  state_d = RESP;
      MERGE: state_d = WR;
      WR: begin
        mem_wrEna = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, load result capture and store word assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      f3_q        <= F3_B;
      err_q       <= 1'b0;
      resp_data_q <= '0;
      wr_data_q   <= '0;
    end else begin
      if (accept) begin
        addr_q      <= req_addr;
        wdata_q     <= req_wdata;
        we_q        <= req_we;
        f3_q        <= req_f3;
        err_q       <= req_err;
        resp_data_q <= '0;
        if (req_we && !req_err) wr_data_q <= req_wdata;
      end
      if (state_q == WAIT)  resp_data_q <= load_data;
      if (state_q == MERGE) wr_data_q   <= store_word;
    end
  end

  assign resp_data  = resp_data_q;
  assign resp_err   = err_q && (state_q == RESP);
  assign mem_rdAddr = {addr_q[N-1:2], 2'b00};
  assign mem_wrAddr = {addr_q[N-1:2], 2'b00};
  assign mem_wrData = wr_data_q;

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Bench for lsu_mem_adapter: word memory model, directed requests, response scoreboard.
// Latency of each response is measured from the accept edge.
// Expectations follow LSU_MISALIGN_CHECK_EN when the bench is built with it.
module tb_lsu_mem_adapter;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_data;
  logic        mem_rdEna, mem_wrEna;
  logic [31:0] mem_rdAddr, mem_wrAddr, mem_wrData, mem_rdData;

  always #5 clk = ~clk;

  lsu_mem_adapter #(.N(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .mem_rdEna(mem_rdEna), .mem_rdAddr(mem_rdAddr),
    .mem_wrEna(mem_wrEna), .mem_wrAddr(mem_wrAddr), .mem_wrData(mem_wrData),
    .mem_rdData(mem_rdData)
  );

  // Memory model: synchronous 1-cycle read, word write, 64 words
  logic [31:0] mem [0:63];
  logic [31:0] rd_q = 32'h0;
  int          rd_cnt = 0, wr_cnt = 0, overlap = 0;
  int          cyc = 0;
  assign mem_rdData = rd_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wrEna) begin
      mem[mem_wrAddr[7:2]] <= mem_wrData;
      wr_cnt++;
    end
    if (mem_rdEna) begin
      rd_q <= mem[mem_rdAddr[7:2]];
      rd_cnt++;
    end
    if (mem_rdEna && mem_wrEna) overlap++;
  end

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // Monitor: every response is popped and compared against the scoreboard
  always @(negedge clk) begin
    if (resp_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got data=%h err=%b, required no response", resp_data, resp_err);
      end else begin
        exp_t e;
        int   lat;
        e   = q.pop_front();
        lat = cyc - e.acc + 1;
        checks += 3;
        if (resp_data !== e.data) begin
          errors++;
          $display("FAIL resp_data: got %h required %h", resp_data, e.data);
        end
        if (resp_err !== e.err) begin
          errors++;
          $display("FAIL resp_err: got %b required %b", resp_err, e.err);
        end
        if (lat != e.lat) begin
          errors++;
          $display("FAIL resp_latency: got %0d required %0d", lat, e.lat);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_data,
                       input logic exp_err, input int lat, input bit want_resp);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: req_ready stayed 0 for addr %h", addr);
      return;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h5A5A_5A5A;
    if (want_resp) begin
      e.data = exp_data;
      e.err  = exp_err;
      e.lat  = lat;
      e.acc  = cyc;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout: %0d responses missing", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, wr0, n;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'h8034_56F0;   // 0x10
    mem[8]  = 32'h1122_3344;   // 0x20
    mem[12] = 32'h5566_7788;   // 0x30

    repeat (2) @(negedge clk);
    chk("rst_req_ready",  {31'b0, req_ready},  32'h1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_resp_err",   {31'b0, resp_err},   32'h0);
    chk("rst_rdEna",      {31'b0, mem_rdEna},  32'h0);
    chk("rst_wrEna",      {31'b0, mem_wrEna},  32'h0);
    chk("rst_resp_data",  resp_data,  32'h0);
    chk("rst_wrData",     mem_wrData, 32'h0);
    rst = 1'b0;

    // Loads: lane extraction and extension, issued back to back
    issue(1'b0, F3_B,  32'h13, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 1'b1);
    issue(1'b0, F3_BU, 32'h13, 32'h0, 32'h0000_0080, 1'b0, 3, 1'b1);
    issue(1'b0, F3_H,  32'h12, 32'h0, 32'hFFFF_8034, 1'b0, 3, 1'b1);
    issue(1'b0, F3_HU, 32'h10, 32'h0, 32'h0000_56F0, 1'b0, 3, 1'b1);
    issue(1'b0, F3_B,  32'h10, 32'h0, 32'hFFFF_FFF0, 1'b0, 3, 1'b1);
    drain();

    // SB: read-modify-write, one read and one write
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b1, F3_B, 32'h21, 32'h0000_00AB, 32'h0, 1'b0, 4, 1'b1);
    drain();
    chk("sb_mem", mem[8], 32'h1122_AB44);
    chk("sb_reads",  32'(rd_cnt - rd0), 32'd1);
    chk("sb_writes", 32'(wr_cnt - wr0), 32'd1);

    // SH into the upper half
    issue(1'b1, F3_H, 32'h22, 32'h0000_CAFE, 32'h0, 1'b0, 4, 1'b1);
    drain();
    chk("sh_mem", mem[8], 32'hCAFE_AB44);

    // SW: direct write, no read
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b1, F3_W, 32'h40, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1'b1);
    drain();
    chk("sw_mem", mem[16], 32'hDEAD_BEEF);
    chk("sw_reads",  32'(rd_cnt - rd0), 32'd0);
    chk("sw_writes", 32'(wr_cnt - wr0), 32'd1);
    issue(1'b0, F3_W, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1'b1);
    drain();

    // Misaligned / illegal requests
    rd0 = rd_cnt; wr0 = wr_cnt;
`ifdef LSU_MISALIGN_CHECK_EN
    issue(1'b0, F3_W,   32'h42, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b0, F3_H,   32'h11, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b1, 3'b100, 32'h44, 32'h0102_0304, 32'h0, 1'b1, 1, 1'b1);
    drain();
    chk("err_reads",  32'(rd_cnt - rd0), 32'd0);
    chk("err_writes", 32'(wr_cnt - wr0), 32'd0);
    chk("err_store_mem", mem[17], 32'h0);
`else
    issue(1'b0, F3_W,   32'h42, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1'b1);
    issue(1'b0, F3_H,   32'h11, 32'h0, 32'h0000_56F0, 1'b0, 3, 1'b1);
    issue(1'b0, 3'b011, 32'h10, 32'h0, 32'h8034_56F0, 1'b0, 3, 1'b1);
    issue(1'b1, 3'b100, 32'h44, 32'h0102_0304, 32'h0, 1'b0, 2, 1'b1);
    drain();
    chk("align_reads",  32'(rd_cnt - rd0), 32'd3);
    chk("align_writes", 32'(wr_cnt - wr0), 32'd1);
    chk("align_store_mem", mem[17], 32'h0102_0304);
`endif

    // Reset during the WR cycle of an SH: no write, no response
    wr0 = wr_cnt;
    issue(1'b1, F3_H, 32'h30, 32'h0000_1234, 32'h0, 1'b0, 0, 1'b0);
    n = 0;
    while (!mem_wrEna && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_saw_wr", {31'b0, mem_wrEna}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_mid_wrEna_drop", {31'b0, mem_wrEna}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_mid_mem", mem[12], 32'h5566_7788);
    chk("rst_mid_writes", 32'(wr_cnt - wr0), 32'd0);

    // Normal operation after reset
    issue(1'b0, F3_W, 32'h30, 32'h0, 32'h5566_7788, 1'b0, 3, 1'b1);
    drain();

    chk("no_rd_wr_overlap", 32'(overlap), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
